// File: rtl/wb_register_file_pkg.sv
// Shared constants for the MEM/WB write-back register file: default widths
// and the positions of the write strobes inside the 17-bit control word.
package wb_register_file_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int CTRL_W    = 17;
  localparam int RF_EN_BIT = 9;
  localparam int HI_EN_BIT = 2;
  localparam int LO_EN_BIT = 1;
  localparam int COUNT_W   = 32;

endpackage : wb_register_file_pkg

// File: rtl/wb_register_file_if.sv
// Write-back and ID-stage read bundle of the register file; the pipeline
// drives it through the master modport, the register file serves the slave side.
interface wb_register_file_if
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              rf_enable;
  logic              hi_enable;
  logic              lo_enable;
  logic              wb_from_mem;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_hi_data;
  logic [DATA_W-1:0] wb_lo_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic [COUNT_W-1:0] wb_count;

  modport master (
    output rf_enable, hi_enable, lo_enable, wb_from_mem, wb_dest,
    output wb_alu_result, wb_mem_data, wb_hi_data, wb_lo_data,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, hi_out, lo_out, wb_count
  );

  modport slave (
    input  rf_enable, hi_enable, lo_enable, wb_from_mem, wb_dest,
    input  wb_alu_result, wb_mem_data, wb_hi_data, wb_lo_data,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, hi_out, lo_out, wb_count
  );

endinterface : wb_register_file_if

// File: rtl/wb_bypass_mux.sv
// One GPR read port: forces register 0 and reset to zero, otherwise forwards
// the in-flight write data when the read address hits the write destination.
module wb_bypass_mux
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  // Read-port select: zero, bypassed write data or stored value.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (!rd_enable || (rd_addr == {ADDR_W{1'b0}})) begin
      rd_data = {DATA_W{1'b0}};
    end else if (wr_valid && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = stored_data;
    end
  end

endmodule : wb_bypass_mux

// File: rtl/wb_register_file.sv
// 32-entry GPR file plus HI/LO with write-through bypass on every read path
// and a retired-write counter for debug.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  wb_register_file_if.slave   bus
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0]  gpr_q [NREGS];
  logic [DATA_W-1:0]  gpr_d [NREGS];
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0]  wr_data_s;
  logic               gpr_wr_s;
  logic [DATA_W-1:0]  hi_out_s, lo_out_s;

  // The only write-data mux; storage and both bypass paths all consume it.
  assign wr_data_s = bus.wb_from_mem ? bus.wb_mem_data : bus.wb_alu_result;
  assign gpr_wr_s  = reset && bus.rf_enable && (bus.wb_dest != {ADDR_W{1'b0}});

  // Next-state for GPRs, HI/LO and the retired-write counter.
  always_comb begin
    gpr_d = gpr_q;
    if (gpr_wr_s) begin
      gpr_d[bus.wb_dest] = wr_data_s;
    end else begin
      gpr_d = gpr_q;
    end
    gpr_d[0] = {DATA_W{1'b0}};
    hi_d     = bus.hi_enable ? bus.wb_hi_data : hi_q;
    lo_d     = bus.lo_enable ? bus.wb_lo_data : lo_q;
    count_d  = gpr_wr_s ? (count_q + 32'd1) : count_q;
  end

  // State registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr_q[i] <= {DATA_W{1'b0}};
      end
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
      count_q <= 32'd0;
    end else begin
      gpr_q   <= gpr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
    .rd_enable   (reset),
    .rd_addr     (bus.rs_addr),
    .stored_data (gpr_q[bus.rs_addr]),
    .wr_valid    (gpr_wr_s),
    .wr_addr     (bus.wb_dest),
    .wr_data     (wr_data_s),
    .rd_data     (bus.rs_data)
  );

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
    .rd_enable   (reset),
    .rd_addr     (bus.rt_addr),
    .stored_data (gpr_q[bus.rt_addr]),
    .wr_valid    (gpr_wr_s),
    .wr_addr     (bus.wb_dest),
    .wr_data     (wr_data_s),
    .rd_data     (bus.rt_data)
  );

  // HI/LO read paths: zero in reset, otherwise bypass a same-cycle write.
  always_comb begin
    hi_out_s = {DATA_W{1'b0}};
    lo_out_s = {DATA_W{1'b0}};
    if (!reset) begin
      hi_out_s = {DATA_W{1'b0}};
      lo_out_s = {DATA_W{1'b0}};
    end else begin
      hi_out_s = bus.hi_enable ? bus.wb_hi_data : hi_q;
      lo_out_s = bus.lo_enable ? bus.wb_lo_data : lo_q;
    end
  end

  assign bus.hi_out   = hi_out_s;
  assign bus.lo_out   = lo_out_s;
  assign bus.wb_count = count_q;

endmodule : wb_register_file

// File: doc/wb_register_file.md
WB_REGISTER_FILE -- requirements
Module: wb_register_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data width.
REQ-002 Parameter ADDR_W, default 5, register address width (32 GPRs).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rf_enable  in  1  GPR write strobe from MEM/WB register (control bit 9).
REQ-006 hi_enable  in  1  HI write strobe from MEM/WB register (control bit 2).
REQ-007 lo_enable  in  1  LO write strobe from MEM/WB register (control bit 1).
REQ-008 wb_from_mem  in  1  1 selects wb_mem_data, 0 selects wb_alu_result.
REQ-009 wb_dest  in  ADDR_W  GPR destination address.
REQ-010 wb_alu_result  in  DATA_W  ALU result to write back.
REQ-011 wb_mem_data  in  DATA_W  load data to write back.
REQ-012 wb_hi_data / wb_lo_data  in  DATA_W each  HI and LO write data.
REQ-013 rs_addr / rt_addr  in  ADDR_W each  ID-stage read addresses.
REQ-014 rs_data / rt_data  out  DATA_W each  ID-stage read data.
REQ-015 hi_out / lo_out  out  DATA_W each  current HI/LO value for MFHI/MFLO.
REQ-016 wb_count  out  32  number of retired GPR writes (debug).

Function
REQ-017 Write data SHALL be wb_mem_data when wb_from_mem=1, else wb_alu_result.
REQ-018 On the rising edge with rf_enable=1 and wb_dest!=0, GPR[wb_dest] SHALL take the write data.
REQ-019 GPR[0] SHALL never be written and SHALL always read 0.
REQ-020 HI SHALL take wb_hi_data on the edge when hi_enable=1; LO independently takes wb_lo_data when lo_enable=1; both may update on the same edge.
REQ-021 GPR, HI and LO writes SHALL be independent; any combination on one edge is legal.
REQ-022 Read ports SHALL be combinational: rs_data = GPR[rs_addr], rt_data = GPR[rt_addr].
REQ-023 Write-through bypass: when rf_enable=1, wb_dest!=0 and a read address equals wb_dest, that port SHALL return the current-cycle write data, not the stored value.
REQ-024 Read address 0 SHALL return 0 even when wb_dest=0 and rf_enable=1.
REQ-025 hi_out/lo_out SHALL likewise bypass wb_hi_data/wb_lo_data when hi_enable/lo_enable=1.
REQ-026 Both read ports addressing the same register SHALL return identical data.
REQ-027 wb_count SHALL increment by 1 on each edge with rf_enable=1 and wb_dest!=0, and wrap from 0xFFFFFFFF to 0.
REQ-028 Write latency: stored value visible without bypass one cycle after the write edge.

Reset
REQ-029 reset low SHALL immediately clear all 32 GPRs, HI, LO and wb_count to 0, independent of clk.
REQ-030 While reset is low, writes SHALL be ignored; read ports SHALL return 0 for all addresses, with bypass disabled.
REQ-031 Writes SHALL resume on the first rising edge after reset deasserts; a write coincident with deassertion is dropped.

Structure
REQ-032 Shared package SHALL hold DATA_W, ADDR_W, control-bit index constants (RF_EN_BIT=9, HI_EN_BIT=2, LO_EN_BIT=1) and the 17-bit control-word width.
REQ-033 One sub-module, wb_bypass_mux, SHALL implement address compare and bypass select and be instanced for rs and rt.
REQ-034 The write-data select of REQ-017 SHALL be a single mux shared by storage and bypass paths.

Verification
REQ-035 Reset low mid-run after writing GPR[5]=0x1234 -> rs_addr=5 reads 0, hi_out=lo_out=0, wb_count=0.
REQ-036 rf_enable=1, wb_dest=0, wb_alu_result=0xDEADBEEF -> rs_addr=0 reads 0 same and next cycle; wb_count unchanged.
REQ-037 rf_enable=1, wb_dest=7, wb_from_mem=1, wb_mem_data=0xCAFEF00D, rs_addr=rt_addr=7 -> both read 0xCAFEF00D same cycle via bypass and after the edge from storage.
REQ-038 hi_enable=1, lo_enable=1, wb_hi_data=0x1, wb_lo_data=0x2 with rf_enable=1 to GPR[3]=0x3 -> all three update on one edge; wb_count +1.
REQ-039 wb_count preloaded to 0xFFFFFFFF by 2^32-1 writes (or forced), one more valid write -> wb_count=0.
REQ-040 Back-to-back writes to GPR[9] with 0x11 then 0x22 -> rt_addr=9 reads 0x11, then 0x22 (bypass), then 0x22 from storage.
